// File: rtl/reg_ctrl_if.sv
// SPI byte side and register-file side of the command decoder.
// slave: the decoder; master: the SPI slave plus register file.
interface reg_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic              spi_cs_n_i;
  logic              spi_byte_vld_i;
  logic [7:0]        spi_byte_data_i;
  logic [7:0]        spi_tx_data_o;
  logic [ADDR_W-1:0] reg_rd_addr_o;
  logic [7:0]        reg_rd_data_i;
  logic              reg_wr_en_o;
  logic [ADDR_W-1:0] reg_wr_addr_o;
  logic [7:0]        reg_wr_data_o;
  logic              cmd_err_o;

  modport slave (
    input  spi_cs_n_i,
    input  spi_byte_vld_i,
    input  spi_byte_data_i,
    output spi_tx_data_o,
    output reg_rd_addr_o,
    input  reg_rd_data_i,
    output reg_wr_en_o,
    output reg_wr_addr_o,
    output reg_wr_data_o,
    output cmd_err_o
  );

  modport master (
    output spi_cs_n_i,
    output spi_byte_vld_i,
    output spi_byte_data_i,
    input  spi_tx_data_o,
    input  reg_rd_addr_o,
    output reg_rd_data_i,
    input  reg_wr_en_o,
    input  reg_wr_addr_o,
    input  reg_wr_data_o,
    input  cmd_err_o
  );
endinterface

// File: rtl/reg_ctrl.sv
// SPI command decoder and register-bus initiator.
// One command byte per frame, then auto-incrementing data/dummy bytes.
module reg_ctrl #(
  parameter int ADDR_W   = 3,
  parameter int REG_BASE = 2
) (
  input logic        clk_i,
  input logic        rst_n_i,
  reg_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    READ,
    DISCARD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        tx_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              err_q;
  logic [6:0]        rsvd;
  logic              wr_ok;

  // Bits above the address field, below the R/W flag, must be zero.
  assign rsvd  = bus.spi_byte_data_i[6:0] >> ADDR_W;
  assign wr_ok = ptr >= ADDR_W'(REG_BASE);

  assign bus.reg_rd_addr_o = ptr;
  assign bus.spi_tx_data_o = tx_q;
  assign bus.reg_wr_en_o   = wr_en_q;
  assign bus.reg_wr_addr_o = wr_addr_q;
  assign bus.reg_wr_data_o = wr_data_q;
  assign bus.cmd_err_o     = err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      ptr       <= '0;
      tx_q      <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      tx_q    <= (state == READ) ? bus.reg_rd_data_i : 8'h00;
      if (bus.spi_cs_n_i) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: state <= CMD;
          CMD: begin
            if (bus.spi_byte_vld_i) begin
              if (rsvd != 7'd0) begin
                state <= DISCARD;
                err_q <= 1'b1;
              end else begin
                ptr   <= bus.spi_byte_data_i[ADDR_W-1:0];
                state <= bus.spi_byte_data_i[7] ? READ : WRITE;
              end
            end
          end
          WRITE: begin
            if (bus.spi_byte_vld_i) begin
              // Read-only addresses still advance the pointer.
              if (wr_ok) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= ptr - ADDR_W'(REG_BASE);
                wr_data_q <= bus.spi_byte_data_i;
              end
              ptr <= ptr + ADDR_W'(1);
            end
          end
          READ: begin
            if (bus.spi_byte_vld_i) ptr <= ptr + ADDR_W'(1);
          end
          DISCARD: state <= DISCARD;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_ctrl.sv
// Directed bench for reg_ctrl: writes, reads, wrap, bad command,
// frame abort and mid-frame reset.
module tb_reg_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_cnt = 0;
  int   err_cnt = 0;
  logic [7:0] mem [8];

  reg_ctrl_if #(.ADDR_W(3)) bus ();

  reg_ctrl #(.ADDR_W(3), .REG_BASE(2)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.reg_rd_data_i = mem[bus.reg_rd_addr_o];

  always @(posedge clk) begin
    #1;
    if (bus.reg_wr_en_o === 1'b1) wr_cnt++;
    if (bus.cmd_err_o === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.spi_byte_vld_i  = 1'b1;
    bus.spi_byte_data_i = b;
    @(negedge clk);
    bus.spi_byte_vld_i  = 1'b0;
    bus.spi_byte_data_i = 8'h00;
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.spi_cs_n_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    bus.spi_cs_n_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input logic en,
                        input logic [2:0] a, input logic [7:0] d);
    chk({tag, ".en"}, 32'(bus.reg_wr_en_o), 32'(en));
    if (en) begin
      chk({tag, ".addr"}, 32'(bus.reg_wr_addr_o), 32'(a));
      chk({tag, ".data"}, 32'(bus.reg_wr_data_o), 32'(d));
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'(i * 3);
    mem[2] = 8'h10;
    mem[3] = 8'h20;
    bus.spi_cs_n_i      = 1'b1;
    bus.spi_byte_vld_i  = 1'b0;
    bus.spi_byte_data_i = 8'h00;
    #12;
    chk("rst.tx", 32'(bus.spi_tx_data_o), 32'h0);
    chk("rst.rd_addr", 32'(bus.reg_rd_addr_o), 32'h0);
    chk("rst.wr_en", 32'(bus.reg_wr_en_o), 32'h0);
    chk("rst.wr_addr", 32'(bus.reg_wr_addr_o), 32'h0);
    chk("rst.wr_data", 32'(bus.reg_wr_data_o), 32'h0);
    chk("rst.err", 32'(bus.cmd_err_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write burst from address 2
    start_frame();
    send(8'h02);
    chk_wr("w1.cmd", 1'b0, 3'd0, 8'h00);
    send(8'h10);
    chk_wr("w1.b0", 1'b1, 3'd0, 8'h10);
    send(8'h20);
    chk_wr("w1.b1", 1'b1, 3'd1, 8'h20);
    send(8'h30);
    chk_wr("w1.b2", 1'b1, 3'd2, 8'h30);
    end_frame();
    chk("w1.count", 32'(wr_cnt), 32'd3);
    chk("w1.err", 32'(err_cnt), 32'd0);

    // read burst from address 2
    start_frame();
    send(8'h82);
    chk("r.addr0", 32'(bus.reg_rd_addr_o), 32'd2);
    chk("r.tx_early", 32'(bus.spi_tx_data_o), 32'h00);
    @(negedge clk);
    chk("r.tx0", 32'(bus.spi_tx_data_o), 32'h10);
    send(8'hFF);
    chk("r.addr1", 32'(bus.reg_rd_addr_o), 32'd3);
    chk("r.tx_hold", 32'(bus.spi_tx_data_o), 32'h10);
    @(negedge clk);
    chk("r.tx1", 32'(bus.spi_tx_data_o), 32'h20);
    end_frame();
    @(negedge clk);
    chk("r.tx_idle", 32'(bus.spi_tx_data_o), 32'h00);
    chk("r.count", 32'(wr_cnt), 32'd3);

    // write at top address, pointer wraps into read-only space
    start_frame();
    send(8'h07);
    send(8'hAA);
    chk_wr("wrap.aa", 1'b1, 3'd5, 8'hAA);
    chk("wrap.ptr0", 32'(bus.reg_rd_addr_o), 32'd0);
    send(8'hBB);
    chk_wr("wrap.bb", 1'b0, 3'd0, 8'h00);
    send(8'hCC);
    chk_wr("wrap.cc", 1'b0, 3'd0, 8'h00);
    chk("wrap.ptr_end", 32'(bus.reg_rd_addr_o), 32'd2);
    end_frame();
    chk("wrap.count", 32'(wr_cnt), 32'd4);

    // reserved bits set: rejected, rest of frame discarded
    start_frame();
    send(8'h48);
    chk("bad.err", 32'(bus.cmd_err_o), 32'd1);
    @(negedge clk);
    chk("bad.err_off", 32'(bus.cmd_err_o), 32'd0);
    send(8'h55);
    chk_wr("bad.data", 1'b0, 3'd0, 8'h00);
    end_frame();
    chk("bad.err_cnt", 32'(err_cnt), 32'd1);
    start_frame();
    send(8'h03);
    send(8'h66);
    chk_wr("bad.next", 1'b1, 3'd1, 8'h66);
    end_frame();
    chk("bad.count", 32'(wr_cnt), 32'd5);

    // cs raised together with a data byte
    start_frame();
    send(8'h02);
    send(8'h11);
    chk_wr("abort.b0", 1'b1, 3'd0, 8'h11);
    @(negedge clk);
    bus.spi_cs_n_i      = 1'b1;
    bus.spi_byte_vld_i  = 1'b1;
    bus.spi_byte_data_i = 8'h99;
    @(negedge clk);
    bus.spi_byte_vld_i  = 1'b0;
    chk_wr("abort.b1", 1'b0, 3'd0, 8'h00);
    start_frame();
    send(8'h02);
    chk_wr("abort.newcmd", 1'b0, 3'd0, 8'h00);
    send(8'h44);
    chk_wr("abort.new_b0", 1'b1, 3'd0, 8'h44);
    end_frame();
    chk("abort.count", 32'(wr_cnt), 32'd7);

    // asynchronous reset while a strobe is high
    start_frame();
    send(8'h03);
    @(negedge clk);
    bus.spi_byte_vld_i  = 1'b1;
    bus.spi_byte_data_i = 8'h21;
    @(posedge clk);
    #2;
    chk("ar.pre_en", 32'(bus.reg_wr_en_o), 32'd1);
    chk("ar.pre_addr", 32'(bus.reg_wr_addr_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar.en", 32'(bus.reg_wr_en_o), 32'd0);
    chk("ar.addr", 32'(bus.reg_wr_addr_o), 32'd0);
    chk("ar.data", 32'(bus.reg_wr_data_o), 32'h0);
    chk("ar.rd_addr", 32'(bus.reg_rd_addr_o), 32'd0);
    chk("ar.tx", 32'(bus.spi_tx_data_o), 32'h0);
    bus.spi_byte_vld_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h04);
    chk_wr("ar.nocmd", 1'b0, 3'd0, 8'h00);
    repeat (3) @(negedge clk);
    end_frame();
    chk("ar.count", 32'(wr_cnt), 32'd8);
    chk("ar.err_cnt", 32'(err_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_ctrl.md
Name: reg_ctrl

Overview:
- Command decoder and register-bus initiator between the SPI slave byte interface and the LED timing/channel register file.
- Parses each chip-select frame: the first byte is a command, the following bytes are write data or read dummies.
- Drives register write strobes and read addresses.
- Returns read bytes to the SPI transmit path with auto-incrementing addresses.

Parameters:
- ADDR_W, 3, register address width; the address space is 2**ADDR_W bytes.
- REG_BASE, 2, first writable address; addresses below REG_BASE are read-only (0 reads 0x00, 1 reads the revision).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- spi_cs_n_i  in  1  frame select, already synchronised to clk_i; low means frame active
- spi_byte_vld_i  in  1  one-cycle pulse: spi_byte_data_i holds a received byte
- spi_byte_data_i  in  8  received byte
- spi_tx_data_o  out  8  byte the SPI slave shifts out on the next transfer
- reg_rd_addr_o  out  ADDR_W  register read address
- reg_rd_data_i  in  8  register read data; combinational from reg_rd_addr_o
- reg_wr_en_o  out  1  one-cycle write strobe
- reg_wr_addr_o  out  ADDR_W  write index, equal to address minus REG_BASE
- reg_wr_data_o  out  8  write data
- cmd_err_o  out  1  one-cycle pulse when a command byte is rejected

Behaviour:
- Reset value of every output register is 0:
  - spi_tx_data_o 0x00, reg_rd_addr_o 0, reg_wr_en_o 0, reg_wr_addr_o 0, reg_wr_data_o 0x00, cmd_err_o 0.
  - State is IDLE and the address pointer is 0.
- Command byte format:
  - bit7: 1 = read, 0 = write.
  - bits6:ADDR_W must be 0.
  - bits ADDR_W-1:0 = start address.
- FSM states: IDLE, CMD, WRITE, READ, DISCARD.
  - IDLE: when spi_cs_n_i is low, go to CMD on the next cycle.
  - CMD: on spi_byte_vld_i, check reserved bits.
    - Nonzero: go to DISCARD and pulse cmd_err_o the next cycle.
    - Zero: load ptr with the start address and go to READ or WRITE per bit7.
  - WRITE: each spi_byte_vld_i writes the byte at ptr, then ptr increments.
  - READ: each spi_byte_vld_i increments ptr.
  - DISCARD: ignore all bytes until the frame ends.
  - Any state: spi_cs_n_i high forces IDLE on the next clock edge. A byte_vld in that same cycle is ignored.
- Write path:
  - reg_wr_en_o pulses exactly one cycle, the cycle after the accepted byte_vld.
  - reg_wr_addr_o = ptr - REG_BASE and reg_wr_data_o = the byte, both registered with the strobe.
  - If ptr < REG_BASE, there is no strobe, but ptr still increments.
- Read path:
  - reg_rd_addr_o is the registered ptr.
  - spi_tx_data_o <= reg_rd_data_i every cycle in READ, so it is valid 1 cycle after ptr changes, i.e. 2 cycles after the command or dummy byte_vld.
  - spi_tx_data_o <= 0x00 in all other states.
  - The byte at the start address is returned during the second transfer, the next address during the third, and so on.
- ptr is ADDR_W bits and wraps 2**ADDR_W-1 -> 0 silently.
- Back-to-back byte_vld pulses are handled one per cycle; there is no backpressure.
- A new frame (spi_cs_n_i high, then low) always restarts at CMD. Partial frames leave already-written registers written.
- Asynchronous reset mid-frame: returns immediately to reset values; no strobe is emitted after reset release until a new command is received.

Test Plan:
- Frame [0x02, 0x10, 0x20, 0x30] -> three wr_en pulses, (addr,data) = (0,0x10), (1,0x20), (2,0x30); nothing else.
- Frame [0x82, dummy, dummy] with the register at address 2 = 0x10 and address 3 = 0x20 -> reg_rd_addr_o 2 then 3; spi_tx_data_o = 0x10 then 0x20, each 2 cycles after the respective byte_vld.
- Frame [0x07, 0xAA, 0xBB, 0xCC] -> write index 5 = 0xAA; ptr wraps to 0 and 1 with no strobes for 0xBB/0xCC; ptr ends at 2.
- Frame [0x48, 0x55] -> cmd_err_o single pulse; no wr_en for 0x55; the next frame [0x03, 0x66] writes index 1 = 0x66.
- spi_cs_n_i raised in the same cycle as a data byte_vld in WRITE -> no strobe for that byte; state IDLE next cycle.
- rst_n_i asserted low between two write data bytes -> outputs 0 asynchronously; after release, a data byte without a command produces no strobe.
